// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared constants and types for the 16x16 weight-stationary systolic array
// sequencer (systolic_ctrl) and its skew/de-skew shift lines.
//   ARRAY_SIZE : rows/columns of the array (fixed at 16)
//   SKEW_DEPTH : deepest skew/de-skew line (ARRAY_SIZE-1)
//   PIPE_LAT   : enabled steps from acceptance to an aligned result vector
//   state_e    : sequencer FSM states
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int ARRAY_SIZE = 16;
  localparam int SKEW_DEPTH = ARRAY_SIZE - 1;
  localparam int PIPE_LAT   = 2 * ARRAY_SIZE - 1;

  localparam int ELEM_W = 8;   // int8 weights and activations
  localparam int SUM_W  = 16;  // per-column partial sum width

  localparam int ROW_W = ELEM_W * ARRAY_SIZE;   // one weight row / input vector
  localparam int RES_W = SUM_W * ARRAY_SIZE;    // one result vector
  localparam int WGT_W = ROW_W * ARRAY_SIZE;    // whole weight matrix

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [RES_W-1:0] res_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
// Enable-gated shift line of DEPTH registers, WIDTH bits each. Used once per
// array row to skew the input vector and once per column to de-skew results.
// Only instantiated for DEPTH >= 1; zero-depth lanes are plain wires in the top.
//   clk    : clock
//   reset  : synchronous, active-high; clears every stage
//   en_i   : shift enable (the array step)
//   d_i    : value entering stage 0
//   q_o    : value leaving the last stage
// -----------------------------------------------------------------------------
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its neighbour's pre-edge value; blocking here would collapse
  // the whole line into a single register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for the 16x16 weight-stationary systolic array. Holds the weight
// matrix, skews accepted int8 input vectors onto the array's left edge, drives
// the array global enable and de-skews the bottom-row sums into whole result
// vectors on a valid/ready output. Any output stall freezes the whole pipeline.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start, num_vec       : begin a job of num_vec vectors (IDLE only)
//   w_wr_en, w_row_addr,
//   w_row_data           : weight row write (IDLE only)
//   in_valid/in_ready,
//   in_data              : input vector stream, element i feeds array row i
//   out_valid/out_ready,
//   out_data             : result stream, column j sum at [16j+15:16j]
//   busy, done           : job in progress / one-cycle completion pulse
//   arr_enable, arr_weight,
//   arr_input, arr_result: connection to the array instance
// -----------------------------------------------------------------------------
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             w_wr_en,
  input  logic [3:0]       w_row_addr,
  input  row_t             w_row_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  row_t             in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output res_t             out_data,
  output logic             busy,
  output logic             done,
  output logic             arr_enable,
  output logic [WGT_W-1:0] arr_weight,
  output row_t             arr_input,
  input  res_t             arr_result
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic                 done_q, done_d;
  logic                 out_valid_q, out_valid_d;
  res_t                 out_data_q, out_data_d;
  // Bit k tags the vector accepted k+1 steps ago as real (1) or bubble (0);
  // out_valid acts as the final stage, giving 32 stages in total.
  logic [PIPE_LAT-1:0]  vld_q, vld_d;
  row_t                 w_q [ARRAY_SIZE];

  logic step;
  logic accept;
  logic out_fire;
  logic wr_fire;
  res_t aligned;

  // ---------------------------------------------------------------------------
  // Handshakes. Nothing moves while a result sits unconsumed at the output.
  // ---------------------------------------------------------------------------
  assign step     = ((state_q == COMPUTE && in_valid) || state_q == DRAIN)
                    && (!out_valid_q || out_ready);
  assign in_ready = (state_q == COMPUTE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign wr_fire  = (state_q == IDLE) && w_wr_en;

  assign arr_enable = step;
  assign busy       = (state_q == COMPUTE) || (state_q == DRAIN);
  assign done       = done_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  // ---------------------------------------------------------------------------
  // Weight store: row i drives PE(i, 0..15).
  // ---------------------------------------------------------------------------
  // NOTE: this small register file is reset on purpose so the array sees an
  // all-zero weight matrix after reset; large RAM-style memories normally are
  // not reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        w_q[r] <= '0;
      end
    end else if (wr_fire) begin
      w_q[w_row_addr] <= w_row_data;
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_wgt
    assign arr_weight[ROW_W*i +: ROW_W] = w_q[i];
  end

  // ---------------------------------------------------------------------------
  // Input skew: row i is delayed by i steps. Bubbles (zeros) enter whenever a
  // step happens without an accepted vector, i.e. during DRAIN.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_skew
    logic [ELEM_W-1:0] elem;
    assign elem = accept ? in_data[ELEM_W*i +: ELEM_W] : '0;

    if (i == 0) begin : g_row0
      assign arr_input[ELEM_W*i +: ELEM_W] = elem;
    end else begin : g_rowi
      skew_line #(
        .DEPTH (i),
        .WIDTH (ELEM_W)
      ) u_skew (
        .clk   (clk),
        .reset (reset),
        .en_i  (step),
        .d_i   (elem),
        .q_o   (arr_input[ELEM_W*i +: ELEM_W])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Output de-skew: column j leaves the array j steps after column 0, so it is
  // delayed by SKEW_DEPTH-j steps to line all columns up.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_deskew
    if (j == SKEW_DEPTH) begin : g_last
      assign aligned[SUM_W*j +: SUM_W] = arr_result[SUM_W*j +: SUM_W];
    end else begin : g_colj
      skew_line #(
        .DEPTH (SKEW_DEPTH - j),
        .WIDTH (SUM_W)
      ) u_deskew (
        .clk   (clk),
        .reset (reset),
        .en_i  (step),
        .d_i   (arr_result[SUM_W*j +: SUM_W]),
        .q_o   (aligned[SUM_W*j +: SUM_W])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, counters, valid pipeline and output register: next-state logic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    vld_d       = vld_q;

    if (step) begin
      vld_d = {vld_q[PIPE_LAT-2:0], accept};
    end

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_cnt_d   = out_cnt_q + CNT_W'(1);
    end

    // A tagged vector reaching the end of the pipe on a step is captured;
    // this may coincide with the previous result being taken.
    if (step && vld_q[PIPE_LAT-1]) begin
      out_valid_d = 1'b1;
      out_data_d  = aligned;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d     = num_vec;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          if (num_vec == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q + CNT_W'(1) == num_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_cnt_q == num_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      num_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      vld_q       <= vld_d;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
// Drives systolic_ctrl against a cycle-level model of the 16x16 PE array and
// compares every result vector with a plain matrix-vector product of the
// weights the bench loaded. Fixed-pattern jobs come from a table with
// hand-computed column sums; corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   num_vec;
  logic          w_wr_en;
  logic [3:0]    w_row_addr;
  logic [127:0]  w_row_data;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [255:0]  out_data;
  logic          busy;
  logic          done;
  logic          arr_enable;
  logic [2047:0] arr_weight;
  logic [127:0]  arr_input;
  logic [255:0]  arr_result;

  systolic_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_vec    (num_vec),
    .w_wr_en    (w_wr_en),
    .w_row_addr (w_row_addr),
    .w_row_data (w_row_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .arr_enable (arr_enable),
    .arr_weight (arr_weight),
    .arr_input  (arr_input),
    .arr_result (arr_result)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Array model: each PE registers its right (activation) and down (sum)
  // outputs on enabled cycles only.
  // ---------------------------------------------------------------------------
  logic [7:0]  a_q [N][N];
  logic [15:0] p_q [N][N];

  function automatic logic [15:0] mac(input logic [15:0] pin, input logic [7:0] w,
                                      input logic [7:0] a);
    int wi, ai, prod;
    wi   = $signed(w);
    ai   = $signed(a);
    prod = wi * ai;
    return pin + prod[15:0];
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_q[i][j] = '0;
        p_q[i][j] = '0;
      end
    end
  end

  always @(posedge clk) begin
    if (arr_enable) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          logic [7:0]  ain;
          logic [15:0] pin;
          ain = (j == 0) ? arr_input[8*i +: 8] : a_q[i][(j == 0) ? 0 : j - 1];
          pin = (i == 0) ? 16'd0 : p_q[(i == 0) ? 0 : i - 1][j];
          a_q[i][j] <= ain;
          p_q[i][j] <= mac(pin, arr_weight[(N*i + j)*8 +: 8], ain);
        end
      end
    end
  end

  always_comb begin
    arr_result = '0;
    for (int j = 0; j < N; j++) begin
      arr_result[16*j +: 16] = p_q[N-1][j];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference: result column j = sum_i w[i][j] * x[i], modulo 2^16.
  // ---------------------------------------------------------------------------
  logic [7:0] wt [N][N];

  function automatic logic [255:0] model(input logic [127:0] x);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < N; i++) begin
        int wi, xi;
        wi = $signed(wt[i][j]);
        xi = $signed(x[8*i +: 8]);
        s  = s + wi * xi;
      end
      r[16*j +: 16] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] pack_row(input int r);
    logic [127:0] d;
    for (int j = 0; j < N; j++) d[8*j +: 8] = wt[r][j];
    return d;
  endfunction

  function automatic int weight_diffs();
    int n;
    n = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (arr_weight[(N*i + j)*8 +: 8] !== wt[i][j]) n++;
    return n;
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_weights(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      w_wr_en    = 1'b1;
      w_row_addr = 4'(r);
      w_row_data = pack_row(r);
      step();
    end
    w_wr_en = 1'b0;
  endtask

  logic [255:0] exp_q[$];
  logic [255:0] got_q[$];
  int           got_cyc[$];
  int           rdy_drop_g;
  bit           fixed_en;
  logic [127:0] fixed_vec;

  // Runs one job: start pulse, then vectors offered with probability vprob %,
  // out_ready high with probability rprob %. After the first result appears,
  // out_ready is forced low for 'hold' cycles. 'poke' fires start/w_wr_en in
  // the first COMPUTE cycle; 'combine_wr' writes row 15 together with start.
  task automatic run_job(input int nvec, input int vprob, input int rprob, input int hold,
                         input bit poke, input bit combine_wr);
    int           sent, cyc, hold_left, stall_bad, rdy_drop;
    bit           seen_out, done_seen, have_pend;
    logic [127:0] pend;
    sent = 0; cyc = 0; hold_left = hold; stall_bad = 0; rdy_drop = 0;
    seen_out = 0; done_seen = 0; have_pend = 0; pend = '0;
    exp_q.delete(); got_q.delete(); got_cyc.delete();

    start   = 1'b1;
    num_vec = 16'(nvec);
    if (combine_wr) begin
      w_wr_en    = 1'b1;
      w_row_addr = 4'd15;
      w_row_data = pack_row(15);
    end
    step();
    start   = 1'b0;
    w_wr_en = 1'b0;

    while (!done_seen && cyc < 3000) begin
      if (sent < nvec && !have_pend) begin
        pend      = fixed_en ? fixed_vec : rand_vec();
        have_pend = 1;
      end
      in_valid = have_pend && ($urandom_range(99) < vprob);
      in_data  = pend;
      if (poke && cyc == 0) begin
        start      = 1'b1;
        num_vec    = 16'd5;
        w_wr_en    = 1'b1;
        w_row_addr = 4'd0;
        w_row_data = {16{8'h7F}};
      end
      if (out_valid) seen_out = 1;
      if (seen_out && hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = ($urandom_range(99) < rprob);
      end
      #1;
      if (out_valid && !out_ready && arr_enable) stall_bad++;
      if (sent < nvec && !in_ready) rdy_drop++;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(pend));
        sent++;
        have_pend = 0;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      if (done) done_seen = 1;
      step();
      start   = 1'b0;
      w_wr_en = 1'b0;
      cyc++;
    end
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    rdy_drop_g = rdy_drop;

    check("job_done_seen", done_seen, 1);
    check("job_accepted", sent, nvec);
    check("job_result_count", got_q.size(), nvec);
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      check("job_result", got_q[k], exp_q[k]);
    end
    check("job_stall_enable_low", stall_bad, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Fixed-pattern job table: uniform weights w, uniform vectors x, expected
  // column sum 16*w*x modulo 2^16 (computed by hand).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  w;
    logic [7:0]  x;
    int          n;
    logic [15:0] e;
  } tbl_t;

  tbl_t tbl [5];

  initial begin
    logic [127:0] x_id;
    logic [255:0] exp_id;
    int           lat, dcyc;
    bit           bad_after_reset;

    tbl[0] = '{w: 8'h02, x: 8'h03, n: 4, e: 16'd96};
    tbl[1] = '{w: 8'hFF, x: 8'h7F, n: 2, e: 16'hF810};
    tbl[2] = '{w: 8'h80, x: 8'h80, n: 1, e: 16'h0000};
    tbl[3] = '{w: 8'h7F, x: 8'h81, n: 2, e: 16'h0FF0};
    tbl[4] = '{w: 8'h80, x: 8'h7F, n: 1, e: 16'h0800};

    reset = 1'b1; start = 1'b0; num_vec = '0; w_wr_en = 1'b0; w_row_addr = '0;
    w_row_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    fixed_en = 0; fixed_vec = '0; rdy_drop_g = 0;

    // ---- reset state ----
    repeat (3) step();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_arr_enable", arr_enable, 0);
    check("rst_arr_input", arr_input, 0);
    check("rst_arr_weight", arr_weight == '0, 1);
    reset = 1'b0;
    step();

    // ---- identity weights, x[i] = i+1 ----
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        wt[i][j] = (i == j) ? 8'd1 : 8'd0;
    load_weights(N);
    #1;
    check("id_weight_bytes_wrong", weight_diffs(), 0);
    out_ready = 1'b1;
    start     = 1'b1;
    num_vec   = 16'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      x_id[8*i +: 8]    = 8'(i + 1);
      exp_id[16*i +: 16] = 16'(i + 1);
    end
    in_valid = 1'b1;
    in_data  = x_id;
    #1;
    check("id_in_ready", in_ready, 1);
    check("id_busy", busy, 1);
    step();
    in_valid = 1'b0;
    in_data  = '0;
    lat = 1;
    while (lat < 100) begin
      #1;
      if (out_valid) break;
      step();
      lat++;
    end
    check("id_latency", lat, 32);
    check("id_result", out_data, exp_id);
    step();
    #1;
    check("id_no_duplicate", out_valid, 0);
    dcyc = 0;
    while (dcyc < 10) begin
      if (done) break;
      step();
      #1;
      dcyc++;
    end
    check("id_done", done, 1);
    check("id_busy_at_done", busy, 0);
    step();
    #1;
    check("id_done_one_cycle", done, 0);

    // ---- table-driven uniform jobs, full throughput ----
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          wt[i][j] = tbl[t].w;
      load_weights(N);
      fixed_en  = 1;
      fixed_vec = {16{tbl[t].x}};
      run_job(tbl[t].n, 100, 100, 0, 0, 0);
      for (int k = 0; k < got_q.size(); k++) begin
        check("tbl_result", got_q[k], {16{tbl[t].e}});
      end
      if (got_q.size() > 0) begin
        check("tbl_consecutive", got_cyc[got_q.size()-1] - got_cyc[0], tbl[t].n - 1);
      end
      check("tbl_in_ready_drop", rdy_drop_g, 0);
    end
    fixed_en = 0;

    // ---- output stalled for 10 cycles during a 3-vector job ----
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        wt[i][j] = 8'($urandom);
    load_weights(N);
    run_job(3, 100, 100, 10, 0, 0);

    // ---- start with num_vec = 0 ----
    start   = 1'b1;
    num_vec = 16'd0;
    #1;
    check("zero_busy_start", busy, 0);
    step();
    start = 1'b0;
    #1;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    step();
    #1;
    check("zero_done_one_cycle", done, 0);

    // ---- start / weight write during COMPUTE are ignored ----
    run_job(2, 100, 100, 0, 1, 0);
    #1;
    check("poke_weight_bytes_wrong", weight_diffs(), 0);

    // ---- reset in DRAIN, then a fresh job ----
    start   = 1'b1;
    num_vec = 16'd2;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = rand_vec();
    step();
    in_data = rand_vec();
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #1;
    check("drain_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_drain_out_valid", out_valid, 0);
    check("rst_drain_busy", busy, 0);
    check("rst_drain_done", done, 0);
    check("rst_drain_arr_weight", arr_weight == '0, 1);
    bad_after_reset = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      #1;
      if (done || out_valid || busy) bad_after_reset = 1;
    end
    check("rst_drain_abandoned", bad_after_reset, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        wt[i][j] = 8'($urandom);
    load_weights(N);
    run_job(3, 100, 100, 0, 0, 0);

    // ---- randomized jobs, random valid/ready, start+write in same cycle ----
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          wt[i][j] = 8'($urandom);
      load_weights(N - 1);
      run_job(int'($urandom_range(40, 1)), 70, 60, 0, 0, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
